usb_tx_serializer: RTL and testbench

//  Upstream stage of the USB transmit NRZI encoder. Accepts packet bytes over a valid/ready handshake and prepends SYNC.

---
 rtl/usb_tx_pkg.sv | 35 +++
 rtl/tx_bit_timer.sv | 49 ++++
 rtl/usb_tx_serializer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit serializer: FSM state encoding,
// line constants and the bit-stuffing run counter helper.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STUFF = 3'd3,
        ST_EOP   = 3'd4,
        ST_EOP_J = 3'd5
    } tx_state_e;

    // SYNC pattern, transmitted LSB-first: seven 0s then a 1
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    // Run of consecutive 1s that forces a stuffed 0
    localparam int STUFF_LEN = 32'sd6;
    // Number of SE0 bit-times at end of packet
    localparam int EOP_BITS = 32'sd2;
    // Width of the ones-run counter (must hold 0..STUFF_LEN)
    localparam int ONES_W = $clog2(STUFF_LEN + 32'sd1);

    // Advance the run-of-ones counter for one transmitted bit
    function automatic logic [ONES_W-1:0] next_ones(input logic [ONES_W-1:0] ones,
                                                    input logic bit_val);
        logic [ONES_W-1:0] result;
        if (bit_val) begin
            result = ones + ONES_W'(1);
        end else begin
            result = {ONES_W{1'b0}};
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and raises a
// registered one-cycle strobe in the cycle where the count sits at its top.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic strobe
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             strobe_r;

    // Next count: clear wins, otherwise wrap at the top of the bit period
    always_comb begin
        cnt_next_s = cnt_r;
        if (clear) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_r == CNT_MAX) begin
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter and look-ahead strobe register (strobe is high while cnt_r == CNT_MAX)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            strobe_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            strobe_r <= enable && !clear && (cnt_next_s == CNT_MAX);
        end
    end

    assign strobe = strobe_r;

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: takes packet bytes over valid/ready, sends SYNC,
// serializes data LSB-first with bit stuffing, then EOP (2x SE0 + 1x J).
// All encoder-facing outputs are registered; only tx_ready is decoded.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_bit,
    output logic       new_bit,
    output logic       eop,
    output logic       idle,
    output logic       tx_busy,
    output logic       tx_underrun
);

    tx_state_e         state_r,      state_next_s;
    logic [2:0]        bit_idx_r,    bit_idx_next_s;
    logic [7:0]        shift_r,      shift_next_s;
    logic              shift_last_r, shift_last_next_s;
    logic [7:0]        hold_r,       hold_next_s;
    logic              hold_full_r,  hold_full_next_s;
    logic              hold_last_r,  hold_last_next_s;
    logic              last_acc_r,   last_acc_next_s;
    logic [ONES_W-1:0] ones_r,       ones_next_s;
    logic              stuff_end_r,  stuff_end_next_s;

    logic              tx_bit_r,   tx_bit_next_s;
    logic              eop_r,      eop_next_s;
    logic              idle_r,     idle_next_s;
    logic              busy_r,     busy_next_s;
    logic              underrun_r, underrun_s;

    logic              tx_ready_s;
    logic              accept_s;
    logic              strobe_s;
    logic              byte_end_s;
    logic [ONES_W-1:0] ones_upd_s;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (state_r == ST_IDLE),
        .enable (state_r != ST_IDLE),
        .strobe (strobe_s)
    );

    // Ready decode: room in hold, packet not closed, not in end-of-packet
    always_comb begin
        tx_ready_s = !hold_full_r && !last_acc_r &&
                     (state_r != ST_EOP) && (state_r != ST_EOP_J);
        accept_s   = tx_valid && tx_ready_s;
    end

    // Next-state, datapath and registered-output look-ahead
    always_comb begin
        state_next_s      = state_r;
        bit_idx_next_s    = bit_idx_r;
        shift_next_s      = shift_r;
        shift_last_next_s = shift_last_r;
        hold_next_s       = hold_r;
        hold_full_next_s  = hold_full_r;
        hold_last_next_s  = hold_last_r;
        last_acc_next_s   = last_acc_r;
        ones_next_s       = ones_r;
        stuff_end_next_s  = stuff_end_r;
        underrun_s        = 1'b0;
        byte_end_s        = 1'b0;
        ones_upd_s        = ones_r;
        tx_bit_next_s     = 1'b1;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s   = ST_SYNC;
                    ones_next_s    = {ONES_W{1'b0}};
                    bit_idx_next_s = 3'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (strobe_s) begin
                    ones_next_s    = next_ones(ones_r, SYNC_BYTE[bit_idx_r]);
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        // First byte moves from hold into the shifter
                        shift_next_s      = hold_r;
                        shift_last_next_s = hold_last_r;
                        hold_full_next_s  = 1'b0;
                        state_next_s      = ST_DATA;
                    end else begin
                        state_next_s = ST_SYNC;
                    end
                end else begin
                    state_next_s = ST_SYNC;
                end
            end
            ST_DATA: begin
                if (strobe_s) begin
                    ones_upd_s     = next_ones(ones_r, shift_r[0]);
                    ones_next_s    = ones_upd_s;
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    bit_idx_next_s = bit_idx_r + 3'd1;
                    if (ones_upd_s == ONES_W'(STUFF_LEN)) begin
                        // Stuff first; the byte-end decision waits until after it
                        state_next_s     = ST_STUFF;
                        stuff_end_next_s = (bit_idx_r == 3'd7);
                    end else if (bit_idx_r == 3'd7) begin
                        byte_end_s = 1'b1;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STUFF: begin
                if (strobe_s) begin
                    ones_next_s      = {ONES_W{1'b0}};
                    stuff_end_next_s = 1'b0;
                    if (stuff_end_r) begin
                        byte_end_s = 1'b1;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_STUFF;
                end
            end
            ST_EOP: begin
                if (strobe_s) begin
                    if (bit_idx_r == 3'(EOP_BITS - 1)) begin
                        state_next_s   = ST_EOP_J;
                        bit_idx_next_s = 3'd0;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_EOP;
                end
            end
            ST_EOP_J: begin
                if (strobe_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EOP_J;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Byte-end decision: finish packet, chain the held byte, or abort
        if (byte_end_s) begin
            bit_idx_next_s = 3'd0;
            if (shift_last_r) begin
                state_next_s = ST_EOP;
            end else if (hold_full_r) begin
                shift_next_s      = hold_r;
                shift_last_next_s = hold_last_r;
                hold_full_next_s  = 1'b0;
                state_next_s      = ST_DATA;
            end else begin
                underrun_s   = 1'b1;
                state_next_s = ST_EOP;
            end
        end else begin
            byte_end_s = 1'b0;
        end

        // A new byte lands in hold after any drain above, so the load wins
        if (accept_s) begin
            hold_next_s      = tx_data;
            hold_full_next_s = 1'b1;
            hold_last_next_s = tx_last;
            last_acc_next_s  = last_acc_r | tx_last;
        end else begin
            hold_next_s = hold_next_s;
        end

        // Returning to idle discards any stray held byte and reopens input
        if (state_next_s == ST_IDLE) begin
            hold_full_next_s = 1'b0;
            last_acc_next_s  = 1'b0;
        end else begin
            last_acc_next_s = last_acc_next_s;
        end

        case (state_next_s)
            ST_IDLE:  tx_bit_next_s = 1'b1;
            ST_SYNC:  tx_bit_next_s = SYNC_BYTE[bit_idx_next_s];
            ST_DATA:  tx_bit_next_s = shift_next_s[0];
            ST_STUFF: tx_bit_next_s = 1'b0;
            ST_EOP:   tx_bit_next_s = 1'b1;
            ST_EOP_J: tx_bit_next_s = 1'b1;
            default:  tx_bit_next_s = 1'b1;
        endcase

        eop_next_s  = (state_next_s == ST_EOP);
        idle_next_s = (state_next_s == ST_IDLE) || (state_next_s == ST_EOP_J);
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= ST_IDLE;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            shift_last_r <= 1'b0;
            hold_r       <= 8'h00;
            hold_full_r  <= 1'b0;
            hold_last_r  <= 1'b0;
            last_acc_r   <= 1'b0;
            ones_r       <= {ONES_W{1'b0}};
            stuff_end_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            bit_idx_r    <= bit_idx_next_s;
            shift_r      <= shift_next_s;
            shift_last_r <= shift_last_next_s;
            hold_r       <= hold_next_s;
            hold_full_r  <= hold_full_next_s;
            hold_last_r  <= hold_last_next_s;
            last_acc_r   <= last_acc_next_s;
            ones_r       <= ones_next_s;
            stuff_end_r  <= stuff_end_next_s;
        end
    end

    // Registered encoder controls, aligned with the state they describe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_bit_r   <= 1'b1;
            eop_r      <= 1'b0;
            idle_r     <= 1'b1;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            tx_bit_r   <= tx_bit_next_s;
            eop_r      <= eop_next_s;
            idle_r     <= idle_next_s;
            busy_r     <= busy_next_s;
            underrun_r <= underrun_s;
        end
    end

    assign tx_ready    = tx_ready_s;
    assign tx_bit      = tx_bit_r;
    assign new_bit     = strobe_s;
    assign eop         = eop_r;
    assign idle        = idle_r;
    assign tx_busy     = busy_r;
    assign tx_underrun = underrun_r;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: directed table of packets,
// hand-written reset/idle sequences and randomized packets, all compared
// against a bit-stream model built from the USB framing rules.
module tb_usb_tx_serializer;

    localparam int         CPB       = 8;
    localparam logic [7:0] SYNC_PAT  = 8'h80;
    localparam int         STUFF_RUN = 6;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, tx_bit, new_bit, eop, idle, tx_busy, tx_underrun;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .tx_bit      (tx_bit),
        .new_bit     (new_bit),
        .eop         (eop),
        .idle        (idle),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bit_v;
        logic eop_v;
        logic idle_v;
    } exp_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nbytes;
        bit         last;
        int         exp_strobes;
        int         exp_underrun;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_strobes, n_underrun, busy_cycles, first_strobe_cyc, acc_cyc, model_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected per-strobe {tx_bit, eop, idle} for a packet, from the framing rules
    function automatic void build_exp(input logic [7:0] pkt[$]);
        logic [7:0] s;
        logic [7:0] b;
        int         ones;
        s    = SYNC_PAT;
        ones = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{s[i], 1'b0, 1'b0});
            ones = s[i] ? ones + 1 : 0;
        end
        for (int k = 0; k < pkt.size(); k++) begin
            b = pkt[k];
            for (int j = 0; j < 8; j++) begin
                exp_q.push_back('{b[j], 1'b0, 1'b0});
                ones = b[j] ? ones + 1 : 0;
                if (ones == STUFF_RUN) begin
                    exp_q.push_back('{1'b0, 1'b0, 1'b0});
                    ones = 0;
                end
            end
        end
        exp_q.push_back('{1'b1, 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b1, 1'b0});
        exp_q.push_back('{1'b1, 1'b0, 1'b1});
    endfunction

    // Monitor: compare every strobed bit and count pulses while enabled
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (tx_busy) busy_cycles++;
                if (tx_underrun) n_underrun++;
                if (new_bit) begin
                    n_strobes++;
                    if (n_strobes == 1) first_strobe_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("extra_strobe", 32'(n_strobes), 32'(model_len));
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("strobe%0d_bit_eop_idle", n_strobes),
                            32'({tx_bit, eop, idle}), 32'({e.bit_v, e.eop_v, e.idle_v}));
                    end
                end
            end
        end
    end

    // Send one packet (bytes held until accepted) and check the full frame
    task automatic run_packet(input logic [7:0] pkt[$], input bit with_last, input int gap_max);
        int waited;
        build_exp(pkt);
        model_len        = exp_q.size();
        n_strobes        = 0;
        n_underrun       = 0;
        busy_cycles      = 0;
        first_strobe_cyc = -1;
        acc_cyc          = -1;
        mon_en           = 1'b1;
        for (int k = 0; k < pkt.size(); k++) begin
            @(negedge clk);
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            tx_data  = pkt[k];
            tx_valid = 1'b1;
            tx_last  = with_last && (k == pkt.size() - 1);
            waited   = 0;
            while (!tx_ready && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            chk("ready_wait", 32'(waited < 2000), 32'd1);
            if (k == 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            if (k == 0) begin
                @(negedge clk);
                chk("idle_drop_after_accept", 32'({idle, tx_busy}), 32'b01);
            end
        end
        waited = 0;
        @(negedge clk);
        while (tx_busy && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        chk("busy_wait", 32'(waited < 4000), 32'd1);
        mon_en = 1'b0;
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("underrun_pulse", 32'(n_underrun), with_last ? 32'd0 : 32'd1);
        chk("first_strobe_delay", 32'(first_strobe_cyc - acc_cyc), 32'(CPB));
        chk("busy_cycles", 32'(busy_cycles), 32'(model_len * CPB));
        chk("idle_after_pkt", 32'({idle, eop, tx_ready, tx_bit, tx_busy}), 32'b10110);
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] pkt[$];
        int         len;
        bit         wl;

        vecs[0] = '{8'h00, 8'h00, 1, 1'b1, 19, 0};
        vecs[1] = '{8'hFF, 8'h00, 1, 1'b1, 20, 0};
        vecs[2] = '{8'hFF, 8'hFF, 2, 1'b1, 29, 0};
        vecs[3] = '{8'h3C, 8'h00, 1, 1'b0, 19, 1};
        vecs[4] = '{8'hFC, 8'h00, 1, 1'b1, 20, 0};

        // Reset, then quiet line for 20 cycles
        repeat (3) @(negedge clk);
        chk("in_reset", 32'({idle, eop, new_bit, tx_ready, tx_bit, tx_busy, tx_underrun}), 32'b1001100);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_line", 32'({idle, eop, new_bit, tx_ready, tx_bit, tx_busy, tx_underrun}),
                32'b1001100);
        end

        // Directed table
        for (int i = 0; i < 5; i++) begin
            pkt.delete();
            pkt.push_back(vecs[i].b0);
            if (vecs[i].nbytes > 1) pkt.push_back(vecs[i].b1);
            run_packet(pkt, vecs[i].last, 0);
            chk($sformatf("tbl%0d_strobes", i), 32'(n_strobes), 32'(vecs[i].exp_strobes));
            chk($sformatf("tbl%0d_underrun", i), 32'(n_underrun), 32'(vecs[i].exp_underrun));
        end

        // Reset in the middle of a data byte
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat ((8 + 3) * CPB + 2) @(negedge clk);
        chk("pre_reset_busy", 32'({tx_busy, eop}), 32'b10);
        n_rst = 1'b0;
        #1;
        chk("reset_mid_data", 32'({idle, eop, tx_ready, new_bit, tx_busy, tx_bit, tx_underrun}),
            32'b1010010);
        @(negedge clk);
        n_rst = 1'b1;
        pkt.delete();
        pkt.push_back(8'h5A);
        run_packet(pkt, 1'b1, 0);

        // Randomized packets with stuffing-heavy bytes
        for (int p = 0; p < 25; p++) begin
            pkt.delete();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            wl = ($urandom_range(0, 3) != 0);
            run_packet(pkt, wl, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
